clz_unit: RTL and testbench
===========================

# clz_unit

Parametrised, multi-cycle leading-zero/leading-one counter for the CPU_54 datapath. It serves the CLZ and CLO instructions and generalises the single-cycle 32-bit counter to any operand width. The operand is scanned CHUNK bits per clock under a start/busy/done handshake, which keeps the critical path short. It sits beside the ALU, and the control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32: operand width in bits. Must be a multiple of `CHUNK` and no greater than 64.
- `CHUNK`, 4: operand bits examined per SCAN cycle. Must be a power of two, at least 1.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request. Sampled only in IDLE or DONE.
- `mode`  in  1  0 = count leading zeros (CLZ), 1 = count leading ones (CLO). Captured with `start`.
- `idata`  in  WIDTH  operand. Captured with `start`.
- `busy`  out  1  high while in SCAN.
- `done`  out  1  one-cycle pulse. `odata` is valid in that cycle.
- `odata`  out  32  count, range 0..WIDTH, zero-extended to 32 bits.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE, `start`=1:
  - Load shift register `sr` with `idata`, or with `~idata` when `mode`=1.
  - Set `acc`=0 and chunk index `k`=0.
  - Go to SCAN.
- SCAN, each cycle, examine the top CHUNK bits of `sr`:
  - If any of those bits is set and no result has been found yet: `result` = `acc` + (leading zeros within the chunk), and set `found`.
  - Otherwise: `acc` += CHUNK.
  - Shift `sr` left by CHUNK and increment `k`.
- SCAN exit:
  - Go to DONE when the configured exit condition holds (see Configuration).
  - If `k` reaches WIDTH/CHUNK with nothing found, `result` = WIDTH.
- DONE, lasting one cycle:
  - `done`=1 and `odata`=`result`.
  - If `start`=1 in this cycle, capture a new operand and go to SCAN (back-to-back operation).
  - Otherwise go to IDLE.
- `odata` holds its value until the next DONE. It is not cleared on IDLE.
- `start` while in SCAN is ignored. `idata` and `mode` may change freely after capture.
- Arithmetic: `acc` and `result` are clog2(WIDTH)+1 bits wide, with no overflow possible. `odata` upper bits are 0.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `odata`=0, `sr`=0, `acc`=0, `k`=0.
- `rst` in any state, including mid-SCAN, aborts the operation in that cycle. No `done` is emitted.
- `rst` has priority over `start` when both are high.
- Let E0 be the edge that samples `start`, and N = WIDTH/CHUNK.
- `busy` is high from E0 until the edge that enters DONE.
- Chunk j (0-based, j=0 is the MSBs) is evaluated at edge E(j+1).
- Early-exit latency: `done` is high in the cycle after E(j+1), so latency is j+1 cycles, where j is the first chunk containing a 1 after the CLO inversion.
- Fixed latency: always N cycles.
- Zero operand (all ones in CLO mode): N cycles in both configurations, `odata`=WIDTH.
- Back-to-back operation: one result per j+2 cycles (early exit) or N+1 cycles (fixed). There is no idle bubble when `start` is held high.

## Configuration
- Macro: `CLZ_UNIT_EARLY_EXIT_EN`.
- Defined: SCAN exits at the edge that sets `found`, or at `k`=N-1. Latency depends on the data.
- Undefined: SCAN always runs all N chunks. `found` freezes `result`, and later chunks do not modify it. Latency is fixed at N, which the control unit can rely on for static stall counting.
- `odata` values are identical in both configurations.

## Test plan
All scenarios use WIDTH=32, CHUNK=4.
- CLZ, `idata`=0x8000_0000 → `odata`=0. Latency is 1 with early exit, 8 without. `done` is high for exactly one cycle.
- CLZ, `idata`=0x0001_0000 → `odata`=15. Latency is 4 with early exit, 8 without.
- CLZ, `idata`=0x0000_0000 → `odata`=32. CLO, `idata`=0xFFFF_FFFF → `odata`=32. Latency is 8 in both configurations.
- CLO, `idata`=0xFFF0_0000 → `odata`=12, latency 4 with early exit. CLO, `idata`=0x7FFF_FFFF → `odata`=0.
- During SCAN, pulse `start` with a new operand, which must be ignored: `odata` is the first operand's result. Then assert `rst` at SCAN cycle 2 of a new operation: `busy`=0, `done` never pulses, `odata`=0 on the next cycle.
- Back-to-back: hold `start` high with operands 0x0000_0001 then 0x4000_0000. Results are 31 then 1, and the second `start` is accepted in the first operation's DONE cycle.

Source files
------------

// File: rtl/clz_unit_if.sv
// Handshake/bus bundle for clz_unit: operand request side and count result side.
interface clz_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] idata;
    logic             busy;
    logic             done;
    logic [31:0]      odata;

    modport master (
        output start, mode, idata,
        input  busy, done, odata
    );

    modport slave (
        input  start, mode, idata,
        output busy, done, odata
    );
endinterface

// File: rtl/clz_unit.sv
// clz_unit: multi-cycle leading-zero / leading-one counter (CLZ/CLO).
// Scans the operand CHUNK bits per clock, MSB chunk first.
// Optional feature macro: CLZ_UNIT_EARLY_EXIT_EN
//   defined   -> SCAN ends on the first chunk containing a 1 (data-dependent latency)
//   undefined -> SCAN always covers all WIDTH/CHUNK chunks (fixed latency)
module clz_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input logic        clk,
    input logic        rst,
    clz_unit_if.slave  bus
);
    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned AW = $clog2(WIDTH) + 1;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic             found_q, found_d;
    logic [31:0]      odata_q, odata_d;

    logic [CHUNK-1:0] chunk;
    logic             chunk_any;
    logic [AW-1:0]    chunk_lz;
    logic             new_hit;
    logic             last_chunk;
    logic             scan_exit;
    logic [AW-1:0]    final_res;

    // Leading-zero count inside the top chunk of the shift register
    always_comb begin
        logic seen;
        chunk     = sr_q[WIDTH-1 -: CHUNK];
        chunk_any = |chunk;
        chunk_lz  = '0;
        seen      = 1'b0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (!seen) begin
                if (chunk[CHUNK-1-i]) begin
                    seen = 1'b1;
                end else begin
                    chunk_lz = chunk_lz + 1'b1;
                end
            end
        end
    end

    // Scan termination and the result that is published on SCAN exit
    always_comb begin
        new_hit    = chunk_any && !found_q;
        last_chunk = (k_q == KW'(N - 1));
`ifdef CLZ_UNIT_EARLY_EXIT_EN
        scan_exit  = new_hit || last_chunk;
`else
        scan_exit  = last_chunk;
`endif
        if (new_hit) begin
            final_res = acc_q + chunk_lz;
        end else if (found_q) begin
            final_res = result_q;
        end else begin
            final_res = AW'(WIDTH);
        end
    end

    // Next-state and datapath update for the IDLE/SCAN/DONE sequencer
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        acc_d    = acc_q;
        result_d = result_q;
        k_d      = k_q;
        found_d  = found_q;
        odata_d  = odata_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    // CLO is counted as CLZ of the inverted operand
                    sr_d     = bus.mode ? ~bus.idata : bus.idata;
                    acc_d    = '0;
                    result_d = '0;
                    k_d      = '0;
                    found_d  = 1'b0;
                    state_d  = S_SCAN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_SCAN: begin
                if (new_hit) begin
                    result_d = acc_q + chunk_lz;
                    found_d  = 1'b1;
                end else begin
                    acc_d    = acc_q + AW'(CHUNK);
                end
                sr_d = sr_q << CHUNK;
                k_d  = k_q + 1'b1;
                if (scan_exit) begin
                    result_d = final_res;
                    odata_d  = 32'(final_res);
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            k_q      <= '0;
            found_q  <= 1'b0;
            odata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            k_q      <= k_d;
            found_q  <= found_d;
            odata_q  <= odata_d;
        end
    end

    assign bus.busy  = (state_q == S_SCAN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.odata = odata_q;

endmodule

// File: tb/tb_clz_unit.sv
// Directed self-checking bench for clz_unit (WIDTH=32, CHUNK=4).
// Expected latencies follow CLZ_UNIT_EARLY_EXIT_EN when it is defined.
module tb_clz_unit;
    localparam int unsigned N = 8;
`ifdef CLZ_UNIT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    clz_unit_if #(.WIDTH(32)) bus ();

    clz_unit #(
        .WIDTH(32),
        .CHUNK(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int j);
        return EE ? (j + 1) : int'(N);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts edges until done is seen (sampled 1 time unit after each edge)
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
        end
    endtask

    task automatic do_op(input string tag, input logic m, input logic [31:0] d,
                         input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.idata = d;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_odata"}, bus.odata, exp_res);
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.idata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_odata", bus.odata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("clz_80000000", 1'b0, 32'h8000_0000, 32'd0,  lat_of(0));
        do_op("clz_00010000", 1'b0, 32'h0001_0000, 32'd15, lat_of(3));
        do_op("clz_zero",     1'b0, 32'h0000_0000, 32'd32, N);
        do_op("clo_ones",     1'b1, 32'hFFFF_FFFF, 32'd32, N);
        do_op("clo_fff00000", 1'b1, 32'hFFF0_0000, 32'd12, lat_of(3));
        do_op("clo_7fffffff", 1'b1, 32'h7FFF_FFFF, 32'd0,  lat_of(0));
        do_op("clz_00000001", 1'b0, 32'h0000_0001, 32'd31, lat_of(7));
        do_op("clz_40000000", 1'b0, 32'h4000_0000, 32'd1,  lat_of(0));

        // start pulsed during SCAN must be ignored
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.idata = 32'h0001_0000;
        @(posedge clk); #1;
        bus.idata = 32'h8000_0000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
        check("ign_lat", 32'(lat + 1), 32'(lat_of(3)));
        check("ign_odata", bus.odata, 32'd15);
        @(posedge clk); #1;
        check("ign_idle", 32'(bus.busy), 32'd0);

        // reset during SCAN cycle 2 aborts without done
        bus.start = 1'b1;
        bus.idata = 32'h0000_0001;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_odata", bus.odata, 32'd0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // rst wins over start on the same edge
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_prio_busy", 32'(bus.busy), 32'd0);

        // back-to-back: start held high through the first DONE
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.idata = 32'h0000_0001;
        @(posedge clk); #1;
        bus.idata = 32'h4000_0000;
        wait_done(lat);
        check("b2b_1_lat", 32'(lat), 32'(lat_of(7)));
        check("b2b_1_odata", bus.odata, 32'd31);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_2_accept", 32'(bus.busy), 32'd1);
        wait_done(lat);
        check("b2b_2_lat", 32'(lat), 32'(lat_of(0)));
        check("b2b_2_odata", bus.odata, 32'd1);
        @(posedge clk); #1;
        check("b2b_idle", 32'(bus.busy | bus.done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
